chunk_serial_adder: RTL

//  Parametrised multi-cycle adder/subtractor for the datapath. Adds or subtracts two WIDTH-bit

---
 rtl/chunk_serial_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle with a registered
// ripple carry, valid/ready handshakes on input and output, and carry/overflow/zero flags.
module chunk_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned NSLOT  = 2 ** CW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_r, b_r, sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [CHUNK-1:0] a_ch [NSLOT];
    logic [CHUNK-1:0] b_ch [NSLOT];
    logic [CHUNK-1:0] s;
    logic             c;

    // Chunk tables are padded to a power of two so cnt indexes them at its exact width.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NCHUNK) begin : g_used
            assign a_ch[g] = a_r[g*CHUNK +: CHUNK];
            assign b_ch[g] = b_r[g*CHUNK +: CHUNK];
            assign sum_next[g*CHUNK +: CHUNK] = (cnt == CW'(g)) ? s : sum[g*CHUNK +: CHUNK];
        end else begin : g_pad
            assign a_ch[g] = '0;
            assign b_ch[g] = '0;
        end
    end

    always_comb begin
        {c, s} = {1'b0, a_ch[cnt]} + {1'b0, b_ch[cnt]} + {{CHUNK{1'b0}}, carry};
        last   = (cnt == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : ci;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    carry <= c;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        co   <= c;
                        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]);
                        zero <= (sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
